// File: rtl/ras_circular_ckpt_pkg.sv
// Shared frontend return-address-stack definitions: checkpoint bundle carried
// with each predicted branch, plus the pointer-width helper.
package ras_circular_ckpt_pkg;

  localparam int unsigned RAS_DEPTH = 32'd2;
  localparam int unsigned RAS_REP_W = 32'd2;

  function automatic int unsigned ras_ptr_w(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

  localparam int unsigned RAS_PTR_W = ras_ptr_w(RAS_DEPTH);

  typedef struct packed {
    logic [RAS_PTR_W-1:0] ptr;
    logic [RAS_PTR_W:0]   cnt;
    logic [RAS_REP_W-1:0] rep;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_circular_ckpt.sv
// Circular return-address stack with pointer checkpoint/restore.
// Optional recursion compression (per-entry repeat counters) under RAS_REPEAT_CNT_EN.
module ras_circular_ckpt
  import ras_circular_ckpt_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned VLEN  = 64,
  parameter int unsigned REP_W = 2,
  parameter int unsigned PTR_W = ras_ptr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_bp_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [VLEN-1:0]  data_i,
  output logic [VLEN-1:0]  data_o,
  output logic             valid_o,
  output logic [PTR_W-1:0] ckpt_ptr_o,
  output logic [PTR_W:0]   ckpt_cnt_o,
  output logic [REP_W-1:0] ckpt_rep_o,
  input  logic             restore_i,
  input  logic [PTR_W-1:0] restore_ptr_i,
  input  logic [PTR_W:0]   restore_cnt_i,
  input  logic [REP_W-1:0] restore_rep_i,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  logic [VLEN-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             we_s;
  logic [PTR_W-1:0] waddr_s;
  logic [PTR_W-1:0] ptr_inc_s;
  logic             rep_clr_all_s;
  logic             rep_we_s;
  logic [PTR_W-1:0] rep_addr_s;
  logic [REP_W-1:0] rep_wdata_s;
  logic [REP_W-1:0] top_rep_s;
  logic             rep_inc_ok_s;

  assign ptr_inc_s = tos_q + PTR_ONE;

  // Next-state decode: flush beats restore, restore beats push/pop.
  always_comb begin
    tos_d         = tos_q;
    cnt_d         = cnt_q;
    ovf_d         = 1'b0;
    unf_d         = 1'b0;
    we_s          = 1'b0;
    waddr_s       = tos_q;
    rep_clr_all_s = 1'b0;
    rep_we_s      = 1'b0;
    rep_addr_s    = tos_q;
    rep_wdata_s   = '0;
    if (flush_bp_i) begin
      cnt_d         = '0;
      rep_clr_all_s = 1'b1;
    end else if (restore_i) begin
      tos_d       = restore_ptr_i;
      cnt_d       = (restore_cnt_i > DEPTH_C) ? DEPTH_C : restore_cnt_i;
      rep_we_s    = 1'b1;
      rep_addr_s  = restore_ptr_i;
      rep_wdata_s = restore_rep_i;
    end else if (push_i && pop_i && (cnt_q != '0)) begin
      // Coroutine swap: replace top in place.
      we_s     = 1'b1;
      waddr_s  = tos_q;
      rep_we_s = 1'b1;
    end else if (push_i) begin
      if (rep_inc_ok_s) begin
        rep_we_s    = 1'b1;
        rep_wdata_s = top_rep_s + REP_ONE;
      end else begin
        tos_d      = ptr_inc_s;
        we_s       = 1'b1;
        waddr_s    = ptr_inc_s;
        rep_we_s   = 1'b1;
        rep_addr_s = ptr_inc_s;
        if (cnt_q == DEPTH_C) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end else if (pop_i) begin
      if (cnt_q == '0) begin
        unf_d = 1'b1;
      end else if (top_rep_s != '0) begin
        rep_we_s    = 1'b1;
        rep_wdata_s = top_rep_s - REP_ONE;
      end else begin
        tos_d = tos_q - PTR_ONE;
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      tos_d = tos_q;
    end
  end

  // Pointer, occupancy and event pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Return-address storage; only one entry is written per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_s) begin
      mem_q[waddr_s] <= data_i;
    end
  end

`ifdef RAS_REPEAT_CNT_EN
  localparam logic [REP_W-1:0] REP_MAX = '1;
  logic [REP_W-1:0] rep_q [DEPTH];

  // Repeat counters: flush clears all, otherwise one addressed update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) rep_q[i] <= '0;
    end else if (rep_clr_all_s) begin
      for (int i = 0; i < DEPTH; i++) rep_q[i] <= '0;
    end else if (rep_we_s) begin
      rep_q[rep_addr_s] <= rep_wdata_s;
    end
  end

  assign top_rep_s    = rep_q[tos_q];
  assign rep_inc_ok_s = (cnt_q != '0) && (data_i == mem_q[tos_q]) && (top_rep_s != REP_MAX);
`else
  logic unused_rep_s;
  assign top_rep_s    = '0;
  assign rep_inc_ok_s = 1'b0;
  assign unused_rep_s = ^{restore_rep_i, rep_we_s, rep_addr_s, rep_wdata_s, rep_clr_all_s};
`endif

  assign data_o      = mem_q[tos_q];
  assign valid_o     = (cnt_q != '0);
  assign ckpt_ptr_o  = tos_q;
  assign ckpt_cnt_o  = cnt_q;
  assign ckpt_rep_o  = top_rep_s;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_ras_circular_ckpt.sv
// Scoreboard bench for ras_circular_ckpt: directed scenarios plus random traffic
// checked against a rule-level stack model.
module tb_ras_circular_ckpt;

  localparam int DEPTH = 4;
  localparam int VLEN  = 32;
  localparam int REP_W = 2;
  localparam int PTR_W = 2;
`ifdef RAS_REPEAT_CNT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             flush_bp_i, push_i, pop_i, restore_i;
  logic [VLEN-1:0]  data_i;
  logic [VLEN-1:0]  data_o;
  logic             valid_o, overflow_o, underflow_o;
  logic [PTR_W-1:0] ckpt_ptr_o, restore_ptr_i;
  logic [PTR_W:0]   ckpt_cnt_o, restore_cnt_i;
  logic [REP_W-1:0] ckpt_rep_o, restore_rep_i;

  always #5 clk = ~clk;

  ras_circular_ckpt #(.DEPTH(DEPTH), .VLEN(VLEN), .REP_W(REP_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i), .push_i(push_i),
    .pop_i(pop_i), .data_i(data_i), .data_o(data_o), .valid_o(valid_o),
    .ckpt_ptr_o(ckpt_ptr_o), .ckpt_cnt_o(ckpt_cnt_o), .ckpt_rep_o(ckpt_rep_o),
    .restore_i(restore_i), .restore_ptr_i(restore_ptr_i),
    .restore_cnt_i(restore_cnt_i), .restore_rep_i(restore_rep_i),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  typedef struct {
    logic [VLEN-1:0] data;
    logic            valid;
    int              ptr;
    int              cnt;
    int              rep;
    logic            ovf;
    logic            unf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: physical ring of return addresses, top index, occupancy,
  // per-slot repeat counts and the last cycle's event flags.
  logic [VLEN-1:0] m_ring[DEPTH];
  int              m_rep[DEPTH];
  int              m_ptr, m_cnt;
  bit              m_ovf, m_unf;
  int              sv_ptr, sv_cnt, sv_rep;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_ring[i] = '0;
      m_rep[i]  = 0;
    end
    m_ptr = 0; m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.data  = m_ring[m_ptr];
    e.valid = (m_cnt != 0);
    e.ptr   = m_ptr;
    e.cnt   = m_cnt;
    e.rep   = REPEAT_EN ? m_rep[m_ptr] : 0;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  task automatic model_step(input bit psh, input bit pp, input logic [VLEN-1:0] d,
                            input bit fl, input bit rs, input int rp, input int rc, input int rr);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (fl) begin
      m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m_rep[i] = 0;
    end else if (rs) begin
      m_ptr = rp;
      m_cnt = (rc > DEPTH) ? DEPTH : rc;
      m_rep[rp] = rr;
    end else if (psh && pp && m_cnt > 0) begin
      m_ring[m_ptr] = d;
      m_rep[m_ptr]  = 0;
    end else if (psh) begin
      if (REPEAT_EN && m_cnt > 0 && m_ring[m_ptr] == d && m_rep[m_ptr] < (1 << REP_W) - 1) begin
        m_rep[m_ptr]++;
      end else begin
        m_ptr = (m_ptr + 1) % DEPTH;
        m_ring[m_ptr] = d;
        m_rep[m_ptr]  = 0;
        if (m_cnt == DEPTH) m_ovf = 1'b1;
        else m_cnt++;
      end
    end else if (pp) begin
      if (m_cnt == 0) m_unf = 1'b1;
      else if (REPEAT_EN && m_rep[m_ptr] > 0) m_rep[m_ptr]--;
      else begin
        m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
        m_cnt--;
      end
    end
  endtask

  // Drive one cycle of requests, then record what the stack must show after the edge.
  task automatic step(input bit psh, input bit pp, input logic [VLEN-1:0] d,
                      input bit fl = 1'b0, input bit rs = 1'b0,
                      input int rp = 0, input int rc = 0, input int rr = 0);
    push_i = psh; pop_i = pp; data_i = d; flush_bp_i = fl; restore_i = rs;
    restore_ptr_i = PTR_W'(rp); restore_cnt_i = (PTR_W+1)'(rc); restore_rep_i = REP_W'(rr);
    @(posedge clk);
    #1;
    model_step(psh, pp, d, fl, rs, rp, rc, rr);
    exp_q.push_back(snap());
    push_i = 1'b0; pop_i = 1'b0; flush_bp_i = 1'b0; restore_i = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, valid_o}, 64'd0);
    check("async_rst_data", {32'd0, data_o}, 64'd0);
    model_reset();
    exp_q.push_back(snap());
    @(negedge clk);
    #2;
    rst_ni = 1'b1;
  endtask

  // Monitor: the stack presents its state every cycle; compare it on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_o", {32'd0, data_o}, {32'd0, e.data});
        check("valid_o", {63'd0, valid_o}, {63'd0, e.valid});
        check("ckpt_ptr_o", {62'd0, ckpt_ptr_o}, 64'(e.ptr));
        check("ckpt_cnt_o", {61'd0, ckpt_cnt_o}, 64'(e.cnt));
        check("ckpt_rep_o", {62'd0, ckpt_rep_o}, 64'(e.rep));
        check("overflow_o", {63'd0, overflow_o}, {63'd0, e.ovf});
        check("underflow_o", {63'd0, underflow_o}, {63'd0, e.unf});
      end
    end
  end

  initial begin
    int r;
    logic [VLEN-1:0] d;
    rst_ni = 1'b0; push_i = 1'b0; pop_i = 1'b0; flush_bp_i = 1'b0; restore_i = 1'b0;
    data_i = '0; restore_ptr_i = '0; restore_cnt_i = '0; restore_rep_i = '0;
    model_reset();
    exp_q.push_back(snap());
    @(negedge clk);
    #2;
    rst_ni = 1'b1;

    // Basic push/pop.
    step(1'b1, 1'b0, 32'h100);
    step(1'b1, 1'b0, 32'h200);
    step(1'b1, 1'b0, 32'h300);
    step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 32'h0);
    // Swap with top 0x300, then flush racing a push.
    step(1'b1, 1'b0, 32'h300);
    step(1'b1, 1'b1, 32'h77);
    step(1'b1, 1'b0, 32'h88, 1'b1);
    // Overflow then underflow.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 32'(i * 16));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 32'h0);
    // Asynchronous reset with three live entries.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h900 + 32'(i));
    async_reset();
    // Checkpoint, mis-speculate, restore.
    step(1'b1, 1'b0, 32'hA);
    step(1'b1, 1'b0, 32'hB);
    sv_ptr = m_ptr; sv_cnt = m_cnt; sv_rep = m_rep[m_ptr];
    step(1'b1, 1'b0, 32'hC);
    step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b1, 32'hD, 1'b0, 1'b1, sv_ptr, sv_cnt, sv_rep);
    // Recursion pattern, then restore with over-range occupancy.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h400);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1, 7, 2);
    // Random traffic from a small address set so repeats and matches occur.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0: d = 32'h400;
        1: d = 32'h500;
        default: d = $urandom;
      endcase
      if (r < 3) step(($urandom % 2) == 1, ($urandom % 2) == 1, d, 1'b1);
      else if (r < 8) step(($urandom % 2) == 1, ($urandom % 2) == 1, d, 1'b0, 1'b1,
                           $urandom_range(0, DEPTH - 1), $urandom_range(0, 7),
                           $urandom_range(0, 3));
      else step($urandom_range(0, 99) < 55, ($urandom % 2) == 1, d);
    end

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
